scalar_mult: RTL and testbench



---
 rtl/scalar_mult.sv | 131 +++++++++++++
 tb/tb_scalar_mult.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/scalar_mult.sv
// scalar_mult: k*P on y^2+xy=x^3+a*x^2+b over GF(2^4); SCALAR_MULT_A_REDUCE_EN reduces a mod f
module scalar_mult (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] k,
    input  logic [3:0] px,
    input  logic [3:0] py,
    input  logic [4:0] a,
    input  logic [4:0] f,
    output logic [3:0] qx,
    output logic [3:0] qy,
    output logic       inf,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LOAD, DBL, ADD, DONE} state_t;

    state_t     state;
    logic [1:0] i;
    logic [3:0] lk, lpx, lpy, ra, rr, rx, ry;
    logic       rinf;
    logic [3:0] a_eff, sx, sy, lam, ax, ay;
    logic [8:0] d_res, a_res, a_step;
    logic       unused_bits;

    function automatic logic [3:0] xor_add(input logic [3:0] in1, input logic [3:0] in2);
        return in1 ^ in2;
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y, input logic [3:0] r);
        logic [3:0] p, t;
        p = '0;
        t = x;
        for (int n = 0; n < 4; n++) begin
            p = y[n] ? xor_add(p, t) : p;
            t = t[3] ? xor_add({t[2:0], 1'b0}, r) : {t[2:0], 1'b0};
        end
        return p;
    endfunction

    // z^14 = z^8 * z^4 * z^2
    function automatic logic [3:0] ginv(input logic [3:0] z, input logic [3:0] r);
        logic [3:0] z2, z4, z8;
        z2 = gmul(z, z, r);
        z4 = gmul(z2, z2, r);
        z8 = gmul(z4, z4, r);
        return gmul(gmul(z8, z4, r), z2, r);
    endfunction

    // {inf, x, y} of 2*(x,y) for a finite point; x = 0 doubles to infinity
    function automatic logic [8:0] dbl(input logic [3:0] x, input logic [3:0] y,
                                       input logic [3:0] ca, input logic [3:0] r);
        logic [3:0] l, nx;
        l  = xor_add(x, gmul(y, ginv(x, r), r));
        nx = xor_add(xor_add(gmul(l, l, r), l), ca);
        return (x == 4'h0) ? 9'h100
                           : {1'b0, nx, xor_add(gmul(x, x, r), gmul(xor_add(l, 4'h1), nx, r))};
    endfunction

`ifdef SCALAR_MULT_A_REDUCE_EN
    assign a_eff = a[4] ? xor_add(a[3:0], f[3:0]) : a[3:0];
`else
    assign a_eff = a[3:0];
`endif
    assign unused_bits = ^{a[4], f[4]};

    // D-step and A-step datapaths on the accumulator R and latched P
    always_comb begin
        d_res  = rinf ? 9'h100 : dbl(rx, ry, ra, rr);
        sx     = xor_add(rx, lpx);
        sy     = xor_add(ry, lpy);
        lam    = gmul(sy, ginv(sx, rr), rr);
        ax     = xor_add(xor_add(xor_add(gmul(lam, lam, rr), lam), sx), ra);
        ay     = xor_add(xor_add(gmul(lam, xor_add(rx, ax), rr), ax), ry);
        a_res  = rinf ? {1'b0, lpx, lpy}
               : (sx != 4'h0) ? {1'b0, ax, ay}
               : (sy == 4'h0) ? dbl(lpx, lpy, ra, rr) : 9'h100;
        a_step = lk[i] ? a_res : {rinf, rx, ry};
    end

    // Control FSM: latch operands, run 4 DBL/ADD pairs MSB-first, publish result
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            {lk, lpx, lpy, ra, rr} <= '0;
            {rinf, rx, ry} <= 9'h100;
            {inf, qx, qy}  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {lk, lpx, lpy, ra, rr} <= {k, px, py, a_eff, f[3:0]};
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    {rinf, rx, ry} <= 9'h100;
                    i     <= 2'd3;
                    busy  <= 1'b1;
                    state <= DBL;
                end
                DBL: begin
                    {rinf, rx, ry} <= d_res;
                    state <= ADD;
                end
                ADD: begin
                    {rinf, rx, ry} <= a_step;
                    if (i == 2'd0) begin
                        {inf, qx, qy} <= a_step;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i     <= i - 2'd1;
                        state <= DBL;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scalar_mult.sv
// tb_scalar_mult: scoreboard bench for scalar_mult with hand-computed GF(2^4) vectors
module tb_scalar_mult;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] k = '0, px = '0, py = '0;
    logic [4:0] a = 5'b10000;
    logic [4:0] f = 5'b10011;
    logic [3:0] qx, qy;
    logic       inf, busy, done;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       inf;
        int         e0;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    scalar_mult dut (
        .clock(clock), .reset(reset), .start(start), .k(k), .px(px), .py(py),
        .a(a), .f(f), .qx(qx), .qy(qy), .inf(inf), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pops one expectation and checks result and 9-edge latency
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.nm, ".qx"}, qx, e.x);
                check({e.nm, ".qy"}, qy, e.y);
                check({e.nm, ".inf"}, inf, e.inf);
                check({e.nm, ".latency"}, cyc - e.e0, 9);
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] x, input logic [3:0] y,
                        input logic i_f, input int e0);
        exp_t e;
        e.nm = nm; e.x = x; e.y = y; e.inf = i_f; e.e0 = e0;
        q.push_back(e);
    endtask

    // Issue one start; returns at the negedge after E0 with start low
    task automatic launch(input string nm, input logic [3:0] kk, input logic [3:0] x0,
                          input logic [3:0] y0, input logic [3:0] ex, input logic [3:0] ey,
                          input logic ei, input logic expect_done);
        @(negedge clock);
        k = kk; px = x0; py = y0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (expect_done) push(nm, ex, ey, ei, cyc);
        start = 1'b0;
        k = ~kk; px = ~x0; py = ~y0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic run(input string nm, input logic [3:0] kk, input logic [3:0] x0,
                       input logic [3:0] y0, input logic [3:0] ex, input logic [3:0] ey,
                       input logic ei);
        launch(nm, kk, x0, y0, ex, ey, ei, 1'b1);
        wait_done();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst.qx", qx, 0);
        check("rst.qy", qy, 0);
        check("rst.inf", inf, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);

        launch("k1_FF", 4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1);
        check("busy_after_E0", busy, 0);
        @(negedge clock);
        check("busy_after_E1", busy, 1);
        wait_done();
        check("busy_after_done", busy, 0);

        run("k0_FF", 4'd0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1);
`ifdef SCALAR_MULT_A_REDUCE_EN
        run("k2_FF", 4'd2, 4'hF, 4'hF, 4'h6, 4'hE, 1'b0);
        run("k3_FF", 4'd3, 4'hF, 4'hF, 4'hC, 4'h5, 1'b0);
`else
        run("k2_FF", 4'd2, 4'hF, 4'hF, 4'h5, 4'hC, 1'b0);
        run("k3_FF", 4'd3, 4'hF, 4'hF, 4'hB, 4'hB, 1'b0);
`endif
        run("k2_05", 4'd2, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1);
        run("k1_05", 4'd1, 4'h0, 4'h5, 4'h0, 4'h5, 1'b0);
        run("k1_C5", 4'd1, 4'hC, 4'h5, 4'hC, 4'h5, 1'b0);

        launch("abort", 4'd3, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort.qx", qx, 0);
        check("abort.qy", qy, 0);
        check("abort.inf", inf, 0);
        check("abort.busy", busy, 0);
        repeat (15) @(negedge clock);
        check("abort.busy_later", busy, 0);

        launch("busy_start", 4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        k = 4'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (14) @(negedge clock);

        begin
            int c;
            @(negedge clock);
            k = 4'd2; px = 4'hF; py = 4'hF; start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            c = cyc;
`ifdef SCALAR_MULT_A_REDUCE_EN
            push("b2b_1", 4'h6, 4'hE, 1'b0, c);
`else
            push("b2b_1", 4'h5, 4'hC, 1'b0, c);
`endif
            push("b2b_2", 4'h0, 4'h0, 1'b1, c + 11);
            px = 4'h0; py = 4'h5;
            repeat (11) @(negedge clock);
            start = 1'b0;
            wait_done();
        end

        repeat (3) @(negedge clock);
        check("pending_expectations", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
